// File: rtl/shift_chk_pkg.sv
// Shared types and constants for the shift-chain tap checker.
//   state_e    : checker FSM states
//   TAP_*      : tap index encodings used by the first-error capture
//   first_tap  : lowest-index mismatching tap, TAP_NONE if none
package shift_chk_pkg;

   localparam int unsigned NUM_TAPS = 3;
   localparam int unsigned TAP_W    = 2;

   typedef enum logic [1:0] {
      WARM  = 2'd0,
      LOCK  = 2'd1,
      FAULT = 2'd2
   } state_e;

   localparam logic [TAP_W-1:0] TAP_NONE = 2'd0;
   localparam logic [TAP_W-1:0] TAP1     = 2'd1;
   localparam logic [TAP_W-1:0] TAP2     = 2'd2;
   localparam logic [TAP_W-1:0] TAP3     = 2'd3;

   // Lowest tap index wins when several taps fail together.
   function automatic logic [TAP_W-1:0] first_tap(input logic [NUM_TAPS:1] mis);
      if (mis[1]) return TAP1;
      if (mis[2]) return TAP2;
      if (mis[3]) return TAP3;
      return TAP_NONE;
   endfunction

endpackage

// File: rtl/shift_tap_history.sv
// Reference history of data_in for a 3-stage shift chain, plus warm-up tracking.
//   clk, rstn : clock, async active-low reset
//   data_in   : word entering the chain
//   h1..h3    : value tap k must currently hold
//   valid[k]  : tap k is qualified (enough edges seen since reset)
module shift_tap_history
   import shift_chk_pkg::*;
#(
   parameter int unsigned DW = 8
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic [DW-1:0]       data_in,
   output logic [DW-1:0]       h1,
   output logic [DW-1:0]       h2,
   output logic [DW-1:0]       h3,
   output logic [NUM_TAPS:1]   valid
);

   localparam int unsigned FILL_W = 2;
   localparam logic [FILL_W-1:0] FILL_MAX = 2'd3;

   logic [FILL_W-1:0]  fill;
   logic [FILL_W-1:0]  fill_nxt;
   logic [NUM_TAPS:1]  valid_nxt;

   // Saturating fill count; valid is registered from the next fill so it tracks fill >= k.
   always_comb begin
      fill_nxt     = (fill == FILL_MAX) ? FILL_MAX : fill + FILL_W'(1);
      valid_nxt[1] = (fill_nxt >= 2'd1);
      valid_nxt[2] = (fill_nxt >= 2'd2);
      valid_nxt[3] = (fill_nxt >= 2'd3);
   end

   // History shifts on every edge, independent of enable or clear.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         h1    <= '0;
         h2    <= '0;
         h3    <= '0;
         fill  <= '0;
         valid <= '0;
      end else begin
         h1    <= data_in;
         h2    <= h1;
         h3    <= h2;
         fill  <= fill_nxt;
         valid <= valid_nxt;
      end
   end

endmodule

// File: rtl/shift_tap_checker.sv
// Receive-side checker for a 3-stage shift chain (data -> tap1 -> tap2 -> tap3).
//   clk, rstn      : clock, async active-low reset
//   en             : enable checking (history/warm-up always advance)
//   clr            : sync clear of flags, count, capture; wins over same-cycle mismatch
//   data_in        : word driven into the chain
//   tap1..tap3     : chain stage outputs under test
//   err_now        : mismatch seen in the previous cycle
//   err_sticky     : bit k-1 set once tap k has mismatched
//   err_cnt        : saturating count of mismatching cycles
//   first_err_tap  : index of first failing tap (0 = none)
//   first_err_val  : observed value of that tap at the first error
//   locked         : checker is in LOCK
module shift_tap_checker
   import shift_chk_pkg::*;
#(
   parameter int unsigned DW    = 8,
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             en,
   input  logic             clr,
   input  logic [DW-1:0]    data_in,
   input  logic [DW-1:0]    tap1,
   input  logic [DW-1:0]    tap2,
   input  logic [DW-1:0]    tap3,
   output logic             err_now,
   output logic [NUM_TAPS-1:0] err_sticky,
   output logic [CNT_W-1:0] err_cnt,
   output logic [TAP_W-1:0] first_err_tap,
   output logic [DW-1:0]    first_err_val,
   output logic             locked
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [DW-1:0]      h1, h2, h3;
   logic [NUM_TAPS:1]  valid;
   logic [NUM_TAPS:1]  mis;
   logic               any_mis;
   logic               hit;
   logic [DW-1:0]      bad_val;
   state_e             state, state_nxt;
   logic               locked_nxt;

   shift_tap_history #(.DW(DW)) u_hist (
      .clk     (clk),
      .rstn    (rstn),
      .data_in (data_in),
      .h1      (h1),
      .h2      (h2),
      .h3      (h3),
      .valid   (valid)
   );

   // Per-tap compare against history; the lowest failing tap supplies the capture value.
   always_comb begin
      mis[1]  = en & valid[1] & (tap1 != h1);
      mis[2]  = en & valid[2] & (tap2 != h2);
      mis[3]  = en & valid[3] & (tap3 != h3);
      any_mis = |mis;
      hit     = any_mis & ~clr;
      bad_val = tap3;
      if (mis[2]) bad_val = tap2;
      if (mis[1]) bad_val = tap1;
   end

   // Error reporting: pulse, sticky flags, saturating count, first-error capture.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         err_now       <= 1'b0;
         err_sticky    <= '0;
         err_cnt       <= '0;
         first_err_tap <= TAP_NONE;
         first_err_val <= '0;
      end else if (clr) begin
         err_now       <= 1'b0;
         err_sticky    <= '0;
         err_cnt       <= '0;
         first_err_tap <= TAP_NONE;
         first_err_val <= '0;
      end else begin
         err_now    <= any_mis;
         err_sticky <= err_sticky | mis;
         if (any_mis && (err_cnt != CNT_MAX)) err_cnt <= err_cnt + CNT_W'(1);
         if (any_mis && (first_err_tap == TAP_NONE)) begin
            first_err_tap <= first_tap(mis);
            first_err_val <= bad_val;
         end
      end
   end

   // FSM state register (locked registered alongside).
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state  <= WARM;
         locked <= 1'b0;
      end else begin
         state  <= state_nxt;
         locked <= locked_nxt;
      end
   end

   // Next state: fill >= 2 now means fill reaches 3 at this edge.
   always_comb begin
      state_nxt = state;
      unique case (state)
         WARM:    if (hit) state_nxt = FAULT;
                  else if (valid[2]) state_nxt = LOCK;
         LOCK:    if (hit) state_nxt = FAULT;
         FAULT:   if (clr) state_nxt = valid[3] ? LOCK : WARM;
         default: state_nxt = WARM;
      endcase
   end

   // Output decode.
   always_comb begin
      locked_nxt = (state_nxt == LOCK);
   end

endmodule

// File: doc/shift_tap_checker.md
Name: shift_tap_checker

Overview:
Receive-side checker for the 3-stage 8-bit shift/register chain (data -> tap1 -> tap2 -> tap3).
- Keeps its own history of data_in.
- Each cycle, compares each incoming tap against the value that tap must hold.
- Reports per-cycle mismatches, per-tap sticky flags, a saturating error count and a first-error capture.
- Sits beside the shift chain in the same clock domain as its self-checking consumer.

Parameters:
DW, 8, data/tap width
CNT_W, 8, error counter width (saturating)

Ports:
clk  in  1  system clock, rising edge
rstn  in  1  reset, asynchronous, active-low
en  in  1  check enable; history and warm-up advance regardless
clr  in  1  synchronous clear of sticky flags, counter, first-error capture
data_in  in  DW  same data word driven into the shift chain
tap1  in  DW  chain stage 1 output
tap2  in  DW  chain stage 2 output
tap3  in  DW  chain stage 3 output
err_now  out  1  registered pulse: mismatch seen in the previous cycle
err_sticky  out  3  bit k-1 set once tap k has mismatched
err_cnt  out  CNT_W  count of cycles with any mismatch, saturating
first_err_tap  out  2  index (1..3) of first failing tap; 0 = none
first_err_val  out  DW  observed (wrong) tap value at first error
locked  out  1  high in state LOCK

Behaviour:
- Clock and reset: one clock domain, clk. Reset is rstn, asynchronous, active-low.
- Reset values: all outputs 0. History h1..h3 = 0, fill = 0, state WARM.
- History:
  - Every rising edge: h1 <= data_in; h2 <= h1; h3 <= h2. Not gated by en or clr.
  - Tap k is expected to equal hk between edges.
- Warm-up:
  - 2-bit fill counter increments per edge after rstn release and saturates at 3.
  - Tap k is qualified only when fill >= k, so tap1 is checked from the cycle after the first edge.
- Compare:
  - mis_k = en & (fill >= k) & (tapk != hk), evaluated combinationally.
  - Results are registered, so latency is 1 cycle: a mismatch during cycle n is reported on outputs after edge n+1.
- err_now: equals OR(mis_1..3) registered. High for exactly one cycle per mismatching cycle.
- err_sticky: bit k-1 is set by mis_k and held until clr or rstn.
- err_cnt:
  - +1 per cycle with any mismatch; multiple taps in one cycle count once.
  - Saturates at 2^CNT_W-1 with no wrap.
- first_err_tap / first_err_val:
  - Loaded only when first_err_tap == 0 and any mis_k.
  - On simultaneous mismatches, the lowest tap index wins.
- FSM:
  - WARM -> LOCK when fill reaches 3 with no mismatch.
  - WARM or LOCK -> FAULT on any registered mismatch, including during warm-up.
  - FAULT -> LOCK on clr when fill == 3; FAULT -> WARM on clr when fill < 3.
  - FAULT persists otherwise.
- clr priority: clr beats the same-cycle mismatch. That cycle's mismatch is discarded (no flag, count or capture) and err_now is 0 next cycle.
- en low: no mismatches are generated; state, flags and count hold.
- rstn assert mid-operation: immediate clear to reset values. Checking restarts through WARM.

Decomposition:
- Package shift_chk_pkg holds:
  - state enum (WARM=2'd0, LOCK=2'd1, FAULT=2'd2)
  - tap index constants TAP_NONE=0, TAP1..TAP3
  - NUM_TAPS=3
- Sub-module shift_tap_history (DW): the 3-deep history register plus fill counter, outputs h1..h3 and valid[3:1].
- Compare, capture and FSM logic stay in the top module.

Test Plan:
1. Reset: hold rstn=0 for 2 cycles with random taps -> all outputs 0, locked=0. Release rstn -> locked=1 after the 3rd edge.
2. Clean stream: data fd,01,ee,82,77,d4, one per cycle, taps from an ideal 3-stage model -> err_now stays 0, err_cnt=0, locked=1 throughout after warm-up.
3. Single fault: expected tap2=01, forced to 00 for one cycle -> next cycle err_now=1 for 1 cycle, err_sticky=3'b010, err_cnt=1, first_err_tap=2, first_err_val=00, state FAULT.
4. Simultaneous faults: tap1 and tap3 both wrong in the same cycle, tap1 driven to 55 -> err_sticky=3'b101, err_cnt increments by 1, first_err_tap=1, first_err_val=55.
5. Saturation: CNT_W=2, 5 consecutive mismatch cycles -> err_cnt sequence 1,2,3,3,3.
6. clr/reset: clr asserted in a mismatching cycle while in FAULT -> all flags 0, err_cnt=0, err_now=0, locked=1. Later, rstn pulsed low mid-LOCK -> outputs 0 immediately (asynchronous), taps ignored until fill qualifies them.
